leddc_frame_tx: RTL and testbench
=================================

Name: leddc_frame_tx

Overview:
- Host-side serializer that drives the LEDDC frame-data input (DAI/DEN) from a word-addressed frame memory.
- On a start pulse it fetches WORDS_PER_FRAME 16-bit grayscale words starting at base_addr.
- Each word is shifted out LSB first on DAI with DEN high for exactly 16 DCK cycles. An inter-word gap with DEN low follows each word.
- Sits between the frame buffer and LEDDC; one instance per LEDDC.

Parameters:
- WORDS_PER_FRAME, 512, words sent per start (16 channels x 32 scanlines); range 1..2^ADDR_W.
- GAP_CYCLES, 2, DEN-low cycles after every word, including the last; must be >= 2.
- ADDR_W, 11, frame memory address width.

Ports:
- DCK  in  1  data clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to send one frame; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; captured when start is accepted.
- rd_en  out  1  memory read strobe, registered.
- rd_addr  out  ADDR_W  memory read address, registered.
- rd_data  in  16  memory data; valid one cycle after rd_en, sampled at the second edge after rd_en rises.
- DAI  out  1  serial data to LEDDC, registered.
- DEN  out  1  data enable to LEDDC, registered.
- busy  out  1  high from start accept until done.
- done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Interface: one clock (DCK); reset is synchronous and active-high (rst).
- Reset values: DAI=0, DEN=0, rd_en=0, rd_addr=0, busy=0, done=0, state=IDLE, word counter=0.
- States and transitions:
  - IDLE: on start=1 at edge E0 -> FETCH; busy=1 from E0; base_addr latched.
  - FETCH: rd_en=1, rd_addr=base at E1; rd_en deasserts at E2; wait.
  - First word: rd_data captured at E3; DEN=1 and DAI=bit0 from E3.
  - SHIFT: DAI presents bits 0..15 on E3..E18, one bit per edge; DEN falls at E3+16.
  - GAP: DEN=0, DAI=0 for GAP_CYCLES cycles.
  - Next-word prefetch: rd_en=1 with rd_addr=next is registered on the same edge DEN falls. Data is captured into a holding register 2 edges later.
  - Next word: DEN rises at DEN-fall edge + GAP_CYCLES.
  - Word k (0-based) therefore starts at E3 + k*(16+GAP_CYCLES).
  - After the last word's gap: done=1 for one cycle, busy=0 on the same edge -> IDLE.
- Addressing: rd_addr = (base + k) mod 2^ADDR_W; wraps silently.
- Word counter is $clog2(WORDS_PER_FRAME+1) bits, compared against WORDS_PER_FRAME-1 to detect the last word.
- start while busy is ignored (no queueing). start on the same edge as done is also ignored; a new start is accepted from the next cycle.
- rst mid-frame: next edge forces all reset values and discards partial words; a following start restarts at word 0.
- DEN never high for other than exactly 16 consecutive cycles. DAI=0 whenever DEN=0.

Optional Feature:
- Macro: LEDDC_TX_MSB_FIRST_EN.
- Defined: bits are shifted MSB first (bit15 on the first DEN-high cycle).
- Undefined (default): LSB first. Timing is identical either way.

Test Plan:
1. Reset: hold rst 3 cycles with start=1 -> DAI=DEN=rd_en=busy=done=0 throughout; no read issued.
2. WORDS_PER_FRAME=1, mem[0]=0x8001, start at E0:
   - rd_en high only E1..E2, addr 0.
   - DEN high E3..E18, DAI = 1,0x14,1.
   - DEN low E19..E20; done pulse at E21.
3. WORDS_PER_FRAME=4, GAP_CYCLES=3, base 0x7FE, ADDR_W=11:
   - Reads 0x7FE, 0x7FF, 0x000, 0x001.
   - DEN rises at E3, E22, E41, E60; done at E79.
4. Default parameters, incrementing pattern:
   - 512 DEN bursts of 16 cycles, last DEN fall at E9219-2=E9217.
   - done at E9219; reconstructed words match memory.
5. start re-pulsed during word 10 and on the done edge -> ignored; frame length and done count unchanged (one done).
6. rst asserted during word 5 bit 7 -> outputs 0 next edge. Subsequent start resends from word 0, with first DEN at start edge + 3.

Source files
------------

// File: rtl/leddc_frame_tx.sv
// LEDDC frame-data serializer: fetches WORDS_PER_FRAME words from frame memory and
// shifts each out on DAI/DEN for 16 DCK cycles. Define LEDDC_TX_MSB_FIRST_EN for MSB-first order.
module leddc_frame_tx #(
    parameter int WORDS_PER_FRAME = 512,
    parameter int GAP_CYCLES      = 2,
    parameter int ADDR_W          = 11
) (
    input  logic              DCK,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              DAI,
    output logic              DEN,
    output logic              busy,
    output logic              done
);
    localparam int CW   = $clog2(WORDS_PER_FRAME + 1);
    localparam int TMAX = (GAP_CYCLES > 16) ? GAP_CYCLES : 16;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] LASTW = CW'(WORDS_PER_FRAME - 1);
    localparam logic [TW-1:0] C1    = TW'(1);
    localparam logic [TW-1:0] C2    = TW'(2);
    localparam logic [TW-1:0] C16   = TW'(16);
    localparam logic [TW-1:0] CGAP  = TW'(GAP_CYCLES);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, GAP} state_t;

    state_t            r_state;
    logic [TW-1:0]     r_cnt;
    logic [CW-1:0]     r_word;
    logic [ADDR_W-1:0] r_base;
    logic [15:0]       r_sh;
    logic [15:0]       r_hold;
    logic              r_rd_d1;

    logic [15:0]       w_word;
    logic              w_first_bit;
    logic [15:0]       w_first_sh;
    logic              w_sh_bit;
    logic [15:0]       w_sh_next;
    logic [CW:0]       w_word_inc;
    logic [ADDR_W-1:0] w_next_addr;

    // Read data lands two edges after rd_en is registered; use it directly on that
    // edge, otherwise the copy parked in r_hold (gaps longer than 2 cycles).
    assign w_word = r_rd_d1 ? rd_data : r_hold;

`ifdef LEDDC_TX_MSB_FIRST_EN
    assign w_first_bit = w_word[15];
    assign w_first_sh  = {w_word[14:0], 1'b0};
    assign w_sh_bit    = r_sh[15];
    assign w_sh_next   = {r_sh[14:0], 1'b0};
`else
    assign w_first_bit = w_word[0];
    assign w_first_sh  = {1'b0, w_word[15:1]};
    assign w_sh_bit    = r_sh[0];
    assign w_sh_next   = {1'b0, r_sh[15:1]};
`endif

    assign w_word_inc  = {1'b0, r_word} + {{CW{1'b0}}, 1'b1};
    assign w_next_addr = r_base + ADDR_W'(w_word_inc);

    always_ff @(posedge DCK) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_word  <= '0;
            r_base  <= '0;
            r_sh    <= '0;
            r_hold  <= '0;
            r_rd_d1 <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            DAI     <= 1'b0;
            DEN     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            rd_en   <= 1'b0;
            done    <= 1'b0;
            r_rd_d1 <= rd_en;
            if (r_rd_d1)
                r_hold <= rd_data;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= FETCH;
                        busy    <= 1'b1;
                        r_base  <= base_addr;
                        r_word  <= '0;
                        r_cnt   <= '0;
                    end
                end
                FETCH: begin
                    if (r_cnt == '0) begin
                        rd_en   <= 1'b1;
                        rd_addr <= r_base;
                    end
                    if (r_cnt == C2) begin
                        DEN     <= 1'b1;
                        DAI     <= w_first_bit;
                        r_sh    <= w_first_sh;
                        r_state <= SHIFT;
                        r_cnt   <= C1;
                    end else begin
                        r_cnt <= r_cnt + C1;
                    end
                end
                SHIFT: begin
                    if (r_cnt == C16) begin
                        DEN     <= 1'b0;
                        DAI     <= 1'b0;
                        r_state <= GAP;
                        r_cnt   <= C1;
                        // Prefetch the next word on the DEN-fall edge so it is ready by the gap end
                        if (r_word != LASTW) begin
                            rd_en   <= 1'b1;
                            rd_addr <= w_next_addr;
                        end
                    end else begin
                        DAI   <= w_sh_bit;
                        r_sh  <= w_sh_next;
                        r_cnt <= r_cnt + C1;
                    end
                end
                GAP: begin
                    if (r_cnt == CGAP) begin
                        if (r_word == LASTW) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_word  <= '0;
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_word  <= r_word + CW'(1);
                            DEN     <= 1'b1;
                            DAI     <= w_first_bit;
                            r_sh    <= w_first_sh;
                            r_state <= SHIFT;
                            r_cnt   <= C1;
                        end
                    end else begin
                        r_cnt <= r_cnt + C1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_leddc_frame_tx.sv
// Bench for leddc_frame_tx: three parameterizations against a timing/bit model
// derived directly from the frame schedule (word k starts at E3 + k*(16+GAP)).
module tb_leddc_frame_tx;
    logic        DCK = 1'b0;
    logic        rst;
    logic [2:0]  st;
    logic [10:0] ba;
    logic [15:0] mem [0:2047];

    logic        rden0, rden1, rden2;
    logic [10:0] addr0, addr1, addr2;
    logic [15:0] rdd0, rdd1, rdd2;
    logic        dai0, dai1, dai2, den0, den1, den2;
    logic        busy0, busy1, busy2, done0, done1, done2;

    int vectors = 0;
    int fails   = 0;

    always #5 DCK = ~DCK;

    leddc_frame_tx #(.WORDS_PER_FRAME(1), .GAP_CYCLES(2), .ADDR_W(11)) u0 (
        .DCK(DCK), .rst(rst), .start(st[0]), .base_addr(ba), .rd_en(rden0), .rd_addr(addr0),
        .rd_data(rdd0), .DAI(dai0), .DEN(den0), .busy(busy0), .done(done0));
    leddc_frame_tx #(.WORDS_PER_FRAME(4), .GAP_CYCLES(3), .ADDR_W(11)) u1 (
        .DCK(DCK), .rst(rst), .start(st[1]), .base_addr(ba), .rd_en(rden1), .rd_addr(addr1),
        .rd_data(rdd1), .DAI(dai1), .DEN(den1), .busy(busy1), .done(done1));
    leddc_frame_tx #(.WORDS_PER_FRAME(512), .GAP_CYCLES(2), .ADDR_W(11)) u2 (
        .DCK(DCK), .rst(rst), .start(st[2]), .base_addr(ba), .rd_en(rden2), .rd_addr(addr2),
        .rd_data(rdd2), .DAI(dai2), .DEN(den2), .busy(busy2), .done(done2));

    // Synchronous frame memory: data valid one cycle after rd_en
    always @(posedge DCK) begin
        if (rden0) rdd0 <= mem[addr0];
        if (rden1) rdd1 <= mem[addr1];
        if (rden2) rdd2 <= mem[addr2];
    end

    function automatic logic [15:0] obs(int d);
        case (d)
            0:       return {busy0, done0, den0, dai0, rden0, rden0 ? addr0 : 11'd0};
            1:       return {busy1, done1, den1, dai1, rden1, rden1 ? addr1 : 11'd0};
            default: return {busy2, done2, den2, dai2, rden2, rden2 ? addr2 : 11'd0};
        endcase
    endfunction

    // Expected {busy,done,DEN,DAI,rd_en,rd_addr} n edges after the start edge
    function automatic logic [15:0] model(logic [10:0] base, int wpf, int gap, int n);
        int p, total, k, m, bi;
        logic b, dn, en, ai, re;
        logic [10:0] a;
        logic [15:0] w;
        p = 16 + gap;
        total = 3 + wpf * p;
        b = (n < total);
        dn = (n == total);
        en = 1'b0; ai = 1'b0; re = 1'b0; a = 11'd0;
        if (n >= 3 && n < total) begin
            k = (n - 3) / p;
            m = (n - 3) % p;
            if (m < 16) begin
                en = 1'b1;
`ifdef LEDDC_TX_MSB_FIRST_EN
                bi = 15 - m;
`else
                bi = m;
`endif
                w = mem[11'(base + k)];
                ai = w[bi];
            end
        end
        if (n == 1) begin
            re = 1'b1; a = base;
        end else if (n >= 19 && (n - 19) % p == 0 && (n - 19) / p < wpf - 1) begin
            re = 1'b1; a = 11'(base + (n - 19) / p + 1);
        end
        return {b, dn, en, ai, re, a};
    endfunction

    task automatic check(string tag, int n, logic [15:0] o, logic [15:0] e);
        vectors++;
        assert (o === e) else begin
            fails++;
            if (fails <= 20)
                $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, n, o, e);
        end
    endtask

    // p1/p2: edges (relative to start edge) that see an extra start pulse; rst_at: edge that sees rst
    task automatic frame(int d, logic [10:0] base, int wpf, int gap, int p1, int p2, int rst_at, string tag);
        int last;
        logic [15:0] e;
        last = (rst_at >= 0) ? rst_at : 3 + wpf * (16 + gap) + 1;
        @(negedge DCK);
        ba = base;
        st[d] = 1'b1;
        for (int n = 0; n <= last; n++) begin
            @(negedge DCK);
            e = (rst_at >= 0 && n >= rst_at) ? 16'h0 : model(base, wpf, gap, n);
            check(tag, n, obs(d), e);
            st = '0;
            if (n + 1 == p1 || n + 1 == p2) st[d] = 1'b1;
            rst = (n + 1 == rst_at);
            ba = 11'($urandom);
        end
        st = '0;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        st  = 3'b111;
        ba  = 11'd0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);

        for (int n = 0; n < 3; n++) begin
            @(negedge DCK);
            for (int d = 0; d < 3; d++) check("reset", n, obs(d), 16'h0);
        end
        rst = 1'b0;
        st  = '0;
        @(negedge DCK);
        for (int d = 0; d < 3; d++) check("idle", 0, obs(d), 16'h0);

        mem[0] = 16'h8001;
        frame(0, 11'd0, 1, 2, -1, -1, -1, "one_word");
        frame(1, 11'h7FE, 4, 3, -1, -1, -1, "wrap_gap3");
        for (int i = 0; i < 4; i++)
            frame(i % 2, 11'($urandom), (i % 2) ? 4 : 1, (i % 2) ? 3 : 2, -1, -1, -1, "rand_small");

        for (int i = 0; i < 2048; i++) mem[i] = 16'(i);
        frame(2, 11'd0, 512, 2, -1, -1, -1, "full_incr");

        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
        frame(2, 11'($urandom), 512, 2, -1, -1, -1, "full_rand");
        frame(2, 11'($urandom), 512, 2, 3 + 10 * 18 + 5, 3 + 512 * 18, -1, "restart_ignored");
        frame(2, 11'($urandom), 512, 2, -1, -1, 3 + 5 * 18 + 7 + 1, "rst_mid");
        frame(2, 11'($urandom), 512, 2, -1, -1, -1, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
